div_seq: RTL and testbench

- Multi-cycle sequencer for the RV32M divide/remainder instructions: DIV, DIVU, REM, REMU.
- Time-shares a single XLEN-bit subtract datapath across 32 restoring-division iterations. The subtract is a + ~b + 1 (cin=1), and carry-out=1 means no borrow.
- Sits beside the ALU in EX. The core stalls on o_busy and collects the result on an o_valid/i_ready handshake.

---
 rtl/div_seq.sv | 181 ++++++++++++++++++
 tb/tb_div_seq.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// div_seq: multi-cycle sequencer for RV32M DIV/DIVU/REM/REMU.
// One XLEN-bit subtractor is reused over 32 restoring-division steps,
// followed by a sign-fix cycle and an o_valid/i_ready result handshake.
// Divide-by-zero and signed overflow resolve at accept, one cycle later.
// Optional feature macro: DIV_SEQ_FLUSH_EN adds an i_flush abort input.
module div_seq #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
`ifdef DIV_SEQ_FLUSH_EN
    input  logic            i_flush,
`endif
    input  logic            i_start,
    input  logic [1:0]      i_op,
    input  logic [XLEN-1:0] i_dividend,
    input  logic [XLEN-1:0] i_divisor,
    output logic            o_busy,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ONE     = {{(XLEN-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic [XLEN-1:0] r_q;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_divisor;
    logic [CW-1:0]   r_cnt;
    logic            r_op_rem;
    logic            r_neg_q;
    logic            r_neg_r;
    logic [XLEN-1:0] r_result;

    logic            w_flush;

`ifdef DIV_SEQ_FLUSH_EN
    assign w_flush = i_flush;
`else
    assign w_flush = 1'b0;
`endif

    // ---------------------------------------------------------------
    // Accept-cycle decode: signedness, magnitudes, special cases
    // ---------------------------------------------------------------
    logic            w_signed;
    logic            w_dvd_neg;
    logic            w_dvs_neg;
    logic [XLEN-1:0] w_dvd_mag;
    logic [XLEN-1:0] w_dvs_mag;
    logic            w_div0;
    logic            w_ovf;
    logic            w_special;
    logic [XLEN-1:0] w_spec_q;
    logic [XLEN-1:0] w_spec_r;

    assign w_signed  = ~i_op[0];
    assign w_dvd_neg = w_signed & i_dividend[XLEN-1];
    assign w_dvs_neg = w_signed & i_divisor[XLEN-1];
    assign w_dvd_mag = w_dvd_neg ? (~i_dividend + ONE) : i_dividend;
    assign w_dvs_mag = w_dvs_neg ? (~i_divisor + ONE) : i_divisor;

    assign w_div0    = (i_divisor == '0);
    assign w_ovf     = w_signed & (i_dividend == MIN_NEG) & (i_divisor == '1);
    assign w_special = w_div0 | w_ovf;
    // Divide-by-zero wins over overflow (divisor cannot be both 0 and -1).
    assign w_spec_q  = w_div0 ? '1 : MIN_NEG;
    assign w_spec_r  = w_div0 ? i_dividend : '0;

    // ---------------------------------------------------------------
    // Iteration datapath: shift one dividend bit in, trial-subtract
    // ---------------------------------------------------------------
    logic [XLEN-1:0] w_shifted;
    logic [XLEN-1:0] w_diff;
    logic            w_carry;
    logic            w_take;
    logic [XLEN-1:0] w_rem_nxt;
    logic [XLEN-1:0] w_q_nxt;
    logic [XLEN-1:0] w_q_fix;
    logic [XLEN-1:0] w_rem_fix;

    assign w_shifted = {r_rem[XLEN-2:0], r_q[XLEN-1]};
    assign {w_carry, w_diff} = {1'b0, w_shifted} + {1'b0, ~r_divisor}
                             + {{XLEN{1'b0}}, 1'b1};
    // The shift drops rem[MSB]; when it was set the true partial remainder
    // is >= 2^XLEN and therefore always exceeds the divisor, so subtract
    // regardless of the carry (only reachable with unsigned divisors >= 2^31).
    assign w_take    = w_carry | r_rem[XLEN-1];
    assign w_rem_nxt = w_take ? w_diff : w_shifted;
    assign w_q_nxt   = {r_q[XLEN-2:0], w_take};

    assign w_q_fix   = r_neg_q ? (~r_q + ONE) : r_q;
    assign w_rem_fix = r_neg_r ? (~r_rem + ONE) : r_rem;

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Next-state and status outputs; flush overrides every transition
    always_comb begin
        w_next  = r_state;
        o_busy  = 1'b1;
        o_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_start) w_next = w_special ? S_DONE : S_CALC;
            end
            S_CALC: if (r_cnt == '0) w_next = S_FIX;
            S_FIX:  w_next = S_DONE;
            S_DONE: begin
                o_valid = 1'b1;
                if (i_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        if (w_flush) w_next = S_IDLE;
    end

    // Operand capture, iteration, sign fix and result register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q       <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
            r_cnt     <= '0;
            r_op_rem  <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_result  <= '0;
        end else if (!w_flush) begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_op_rem  <= i_op[1];
                        r_neg_q   <= w_dvd_neg ^ w_dvs_neg;
                        r_neg_r   <= w_dvd_neg;
                        r_divisor <= w_dvs_mag;
                        r_cnt     <= CW'(XLEN-1);
                        if (w_special) begin
                            r_q      <= w_spec_q;
                            r_rem    <= w_spec_r;
                            r_result <= i_op[1] ? w_spec_r : w_spec_q;
                        end else begin
                            r_q      <= w_dvd_mag;
                            r_rem    <= '0;
                        end
                    end
                end
                S_CALC: begin
                    r_rem <= w_rem_nxt;
                    r_q   <= w_q_nxt;
                    r_cnt <= r_cnt - CW'(1);
                end
                S_FIX: begin
                    r_q      <= w_q_fix;
                    r_rem    <= w_rem_fix;
                    r_result <= r_op_rem ? w_rem_fix : w_q_fix;
                end
                default: ;
            endcase
        end
    end

    assign o_result = r_result;

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed + randomized checks of div_seq against an
// arithmetic reference model (plain / and %, RISC-V corner rules).
module tb_div_seq;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_start;
    logic [1:0]  i_op;
    logic [31:0] i_dividend;
    logic [31:0] i_divisor;
    logic        o_busy;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_result;
`ifdef DIV_SEQ_FLUSH_EN
    logic        i_flush;
`endif

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

    div_seq #(.XLEN(32)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
`ifdef DIV_SEQ_FLUSH_EN
        .i_flush    (i_flush),
`endif
        .i_start    (i_start),
        .i_op       (i_op),
        .i_dividend (i_dividend),
        .i_divisor  (i_divisor),
        .o_busy     (o_busy),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_result   (o_result)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // RISC-V M semantics from plain arithmetic
    function automatic logic [31:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        int sa, sb;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                return op[1] ? 32'd0 : 32'h8000_0000;
            sa = a;
            sb = b;
            return op[1] ? 32'(sa % sb) : 32'(sa / sb);
        end
        return op[1] ? (a % b) : (a / b);
    endfunction

    function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        if (b == 32'd0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    // Issue one op at a negedge; check latency, result, hold under
    // backpressure (optionally poking i_start) and return to idle.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int hold, input bit poke);
        logic [31:0] exp;
        int          k;
        exp        = ref_model(op, a, b);
        i_start    = 1'b1;
        i_op       = op;
        i_dividend = a;
        i_divisor  = b;
        i_ready    = 1'b0;
        @(posedge i_clk);
        @(negedge i_clk);
        i_start    = 1'b0;
        i_op       = 2'($urandom);
        i_dividend = $urandom;
        i_divisor  = $urandom;
        check("busy_t1", {31'd0, o_busy}, 32'd1);
        k = 1;
        while (!o_valid && k < 100) begin
            @(posedge i_clk);
            @(negedge i_clk);
            k++;
        end
        check("latency", k, ref_latency(op, a, b));
        check("result", o_result, exp);
        for (int h = 0; h < hold; h++) begin
            i_start = poke;
            @(posedge i_clk);
            @(negedge i_clk);
            check("hold_valid", {31'd0, o_valid}, 32'd1);
            check("hold_result", o_result, exp);
        end
        i_ready = 1'b1;
        i_start = poke;
        @(posedge i_clk);
        @(negedge i_clk);
        i_ready = 1'b0;
        i_start = 1'b0;
        check("idle_busy", {31'd0, o_busy}, 32'd0);
        check("idle_valid", {31'd0, o_valid}, 32'd0);
        check("idle_result", o_result, exp);
    endtask

    function automatic logic [31:0] rand_operand(input int mode);
        case (mode)
            0:       return 32'd0;
            1:       return 32'($urandom_range(1, 50));
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 50));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] a, b;
        logic [1:0]  op;
        i_rst_n    = 1'b0;
        i_start    = 1'b0;
        i_op       = 2'b00;
        i_dividend = 32'd0;
        i_divisor  = 32'd0;
        i_ready    = 1'b0;
`ifdef DIV_SEQ_FLUSH_EN
        i_flush    = 1'b0;
`endif
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_valid", {31'd0, o_valid}, 32'd0);
        check("rst_result", o_result, 32'd0);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // Directed cases
        run_op(OP_DIVU, 32'd100, 32'd7, 0, 1'b0);
        run_op(OP_REMU, 32'd100, 32'd7, 0, 1'b0);
        run_op(OP_DIV,  32'hFFFF_FFF9, 32'd2, 0, 1'b0);
        run_op(OP_REM,  32'hFFFF_FFF9, 32'd2, 0, 1'b0);
        run_op(OP_DIV,  32'd7, 32'hFFFF_FFFE, 0, 1'b0);
        run_op(OP_REM,  32'd7, 32'hFFFF_FFFE, 0, 1'b0);
        run_op(OP_DIVU, 32'd5, 32'd0, 0, 1'b0);
        run_op(OP_REM,  32'd5, 32'd0, 0, 1'b0);
        run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        run_op(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        run_op(OP_DIVU, 32'hFFFF_FFFF, 32'd1, 5, 1'b1);
        run_op(OP_REMU, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1, 1'b0);

        // Asynchronous reset in the middle of an operation
        i_start    = 1'b1;
        i_op       = OP_DIVU;
        i_dividend = 32'd1000;
        i_divisor  = 32'd3;
        @(posedge i_clk);
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (9) @(posedge i_clk);
        #2 i_rst_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, o_busy}, 32'd0);
        check("arst_valid", {31'd0, o_valid}, 32'd0);
        check("arst_result", o_result, 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        run_op(OP_DIVU, 32'd9, 32'd3, 0, 1'b0);

`ifdef DIV_SEQ_FLUSH_EN
        begin
            bit seen_valid;
            i_start    = 1'b1;
            i_op       = OP_DIVU;
            i_dividend = 32'd12345;
            i_divisor  = 32'd7;
            @(posedge i_clk);
            @(negedge i_clk);
            i_start = 1'b0;
            repeat (19) @(posedge i_clk);
            @(negedge i_clk);
            i_flush    = 1'b1;
            i_start    = 1'b1;
            i_divisor  = 32'd0;
            @(posedge i_clk);
            @(negedge i_clk);
            i_flush = 1'b0;
            i_start = 1'b0;
            check("flush_busy", {31'd0, o_busy}, 32'd0);
            check("flush_valid", {31'd0, o_valid}, 32'd0);
            seen_valid = 1'b0;
            i_ready    = 1'b1;
            repeat (40) begin
                @(posedge i_clk);
                @(negedge i_clk);
                if (o_valid || o_busy) seen_valid = 1'b1;
            end
            i_ready = 1'b0;
            check("flush_quiet", {31'd0, seen_valid}, 32'd0);
            run_op(OP_DIV, 32'hFFFF_FF00, 32'd16, 0, 1'b0);
        end
`endif

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom);
            a  = rand_operand($urandom_range(0, 9));
            b  = rand_operand($urandom_range(0, 9));
            run_op(op, a, b, $urandom_range(0, 3), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
